// File: rtl/mf_clken_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mf_clken_pkg
// Purpose  : Shared types and helpers for the multi-channel clock-enable NCO.
//            Holds the controller state encoding, default sizing constants and
//            a helper that turns a target enable frequency into an increment.
// Revision : 1.0 - initial release
// ============================================================================
package mf_clken_pkg;

    // Controller states: wait for synchronised lock, let it settle, then run.
    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } state_t;

    localparam int c_DEF_NUM_CH = 4;
    localparam int c_DEF_ACC_W  = 32;

    // Increment that yields f_out_hz enables from an f_ref_hz clock with the
    // default accumulator width: inc = f_out * 2^ACC_W / f_ref (truncated).
    function automatic logic [63:0] inc_for(input logic [63:0] f_out_hz,
                                            input logic [63:0] f_ref_hz);
        logic [127:0] num;
        logic [127:0] quo;
        num = {64'd0, f_out_hz} << c_DEF_ACC_W;
        if (f_ref_hz == 64'd0) begin
            quo = 128'd0;
        end else begin
            quo = num / {64'd0, f_ref_hz};
        end
        return quo[63:0];
    endfunction

endpackage : mf_clken_pkg
`default_nettype wire

// File: rtl/mf_nco_ch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mf_nco_ch
// Purpose  : One phase-accumulator channel. Holds its increment and phase
//            offset, accumulates while enabled and emits the registered carry
//            as a one-cycle enable pulse.
// Ports    : clk, rst        - clock, asynchronous active-high reset
//            en_i            - accumulate this cycle
//            load_i          - reload accumulator from the phase offset
//            cfg_we_i        - store cfg_inc_i/cfg_phase_i and load acc
//            cfg_inc_i       - new increment
//            cfg_phase_i     - new phase offset
//            ce_o            - enable pulse (registered carry)
// Revision : 1.0 - initial release
// ============================================================================
module mf_nco_ch #(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             load_i,
    input  logic             cfg_we_i,
    input  logic [ACC_W-1:0] cfg_inc_i,
    input  logic [ACC_W-1:0] cfg_phase_i,
    output logic             ce_o
);

    logic [ACC_W-1:0] inc_q;
    logic [ACC_W-1:0] phase_q;
    logic [ACC_W-1:0] phase_d;
    logic [ACC_W-1:0] acc_q;
    logic             ce_q;
    logic [ACC_W:0]   w_sum;

    // A reload coinciding with a retune must use the phase being written.
    assign phase_d = cfg_we_i ? cfg_phase_i : phase_q;
    assign w_sum   = {1'b0, acc_q} + {1'b0, inc_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inc_q   <= '0;
            phase_q <= '0;
            acc_q   <= '0;
            ce_q    <= 1'b0;
        end else begin
            if (cfg_we_i) begin
                inc_q   <= cfg_inc_i;
                phase_q <= cfg_phase_i;
            end
            // Both a realign/run-entry reload and a retune restart the
            // accumulator from the (possibly new) phase and suppress ce.
            if (load_i || cfg_we_i) begin
                acc_q <= phase_d;
                ce_q  <= 1'b0;
            end else if (en_i) begin
                acc_q <= w_sum[ACC_W-1:0];
                ce_q  <= w_sum[ACC_W];
            end else begin
                ce_q  <= 1'b0;
            end
        end
    end

    assign ce_o = ce_q;

endmodule : mf_nco_ch
`default_nettype wire

// File: rtl/mf_clken_nco.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mf_clken_nco
// Purpose  : Multi-channel fractional clock-enable generator on the PLL output
//            clock. Enables run only after PLL lock has been stable for
//            SETTLE_CYC cycles; supports runtime retune and global realign.
// Ports    : refclk        - clock (PLL output domain)
//            rst           - asynchronous reset, active-high
//            pll_locked    - PLL lock, asynchronous to refclk
//            cfg_valid/cfg_ready - retune handshake
//            cfg_ch        - channel to retune (out-of-range is ignored)
//            cfg_inc       - new increment (rate = inc/2^ACC_W)
//            cfg_phase     - new phase offset
//            realign       - reload all accumulators from their phases
//            ce            - per-channel enable pulses
//            running       - high while in RUN
//            lock_lost_cnt - saturating count of lock losses during RUN
// Revision : 1.0 - initial release
// ============================================================================
module mf_clken_nco
    import mf_clken_pkg::*;
#(
    parameter int NUM_CH     = c_DEF_NUM_CH,
    parameter int ACC_W      = c_DEF_ACC_W,
    parameter int SETTLE_CYC = 1024,
    parameter int CNT_W      = 8
) (
    input  logic                                      refclk,
    input  logic                                      rst,
    input  logic                                      pll_locked,
    input  logic                                      cfg_valid,
    output logic                                      cfg_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [ACC_W-1:0]                          cfg_inc,
    input  logic [ACC_W-1:0]                          cfg_phase,
    input  logic                                      realign,
    output logic [NUM_CH-1:0]                         ce,
    output logic                                      running,
    output logic [CNT_W-1:0]                          lock_lost_cnt
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] c_SETTLE_LAST = SET_W'(SETTLE_CYC - 1);

    logic             lk_meta_q;
    logic             lk_s_q;
    state_t           state_q;
    logic [SET_W-1:0] settle_cnt_q;
    logic             running_q;
    logic             cfg_ready_q;
    logic [CNT_W-1:0] lock_lost_q;

    logic              w_cfg_fire;
    logic              w_settle_done;
    logic              w_run_en;
    logic              w_load;
    logic [NUM_CH-1:0] w_ce;

    assign w_cfg_fire    = cfg_valid & cfg_ready_q;
    assign w_settle_done = (state_q == SETTLE) && lk_s_q && (settle_cnt_q == c_SETTLE_LAST);
    // Gating on lk_s makes ce drop on the very edge that sees lock fall.
    assign w_run_en      = (state_q == RUN) && lk_s_q;
    assign w_load        = w_settle_done | (w_run_en & realign);

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            lk_meta_q    <= 1'b0;
            lk_s_q       <= 1'b0;
            state_q      <= WAIT_LOCK;
            settle_cnt_q <= '0;
            running_q    <= 1'b0;
            cfg_ready_q  <= 1'b0;
            lock_lost_q  <= '0;
        end else begin
            lk_meta_q   <= pll_locked;
            lk_s_q      <= lk_meta_q;
            cfg_ready_q <= 1'b1;
            case (state_q)
                WAIT_LOCK: begin
                    settle_cnt_q <= '0;
                    running_q    <= 1'b0;
                    if (lk_s_q) begin
                        state_q <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (!lk_s_q) begin
                        state_q      <= WAIT_LOCK;
                        settle_cnt_q <= '0;
                    end else if (settle_cnt_q == c_SETTLE_LAST) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (!lk_s_q) begin
                        state_q   <= WAIT_LOCK;
                        running_q <= 1'b0;
                        if (lock_lost_q != {CNT_W{1'b1}}) begin
                            lock_lost_q <= lock_lost_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q   <= WAIT_LOCK;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic w_we;
        // Unused codes of cfg_ch match no channel and are silently dropped.
        assign w_we = w_cfg_fire && (cfg_ch == CH_W'(g));

        mf_nco_ch #(
            .ACC_W (ACC_W)
        ) u_ch (
            .clk         (refclk),
            .rst         (rst),
            .en_i        (w_run_en),
            .load_i      (w_load),
            .cfg_we_i    (w_we),
            .cfg_inc_i   (cfg_inc),
            .cfg_phase_i (cfg_phase),
            .ce_o        (w_ce[g])
        );
    end

    assign ce            = w_ce;
    assign running       = running_q;
    assign cfg_ready     = cfg_ready_q;
    assign lock_lost_cnt = lock_lost_q;

endmodule : mf_clken_nco
`default_nettype wire

// File: tb/tb_mf_clken_nco.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mf_clken_nco
// Purpose  : Directed self-checking bench for mf_clken_nco (4 channels,
//            32-bit accumulators, 16-cycle settle).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mf_clken_nco;

    localparam int NUM_CH     = 4;
    localparam int ACC_W      = 32;
    localparam int SETTLE_CYC = 16;
    localparam int CNT_W      = 8;
    localparam int LOCK_LAT   = 2 + SETTLE_CYC + 1;

    logic              refclk;
    logic              rst;
    logic              pll_locked;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_ch;
    logic [ACC_W-1:0]  cfg_inc;
    logic [ACC_W-1:0]  cfg_phase;
    logic              realign;
    logic [NUM_CH-1:0] ce;
    logic              running;
    logic [CNT_W-1:0]  lock_lost_cnt;

    int checks = 0;
    int errors = 0;

    mf_clken_nco #(
        .NUM_CH     (NUM_CH),
        .ACC_W      (ACC_W),
        .SETTLE_CYC (SETTLE_CYC),
        .CNT_W      (CNT_W)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .cfg_valid     (cfg_valid),
        .cfg_ready     (cfg_ready),
        .cfg_ch        (cfg_ch),
        .cfg_inc       (cfg_inc),
        .cfg_phase     (cfg_phase),
        .realign       (realign),
        .ce            (ce),
        .running       (running),
        .lock_lost_cnt (lock_lost_cnt)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic [ACC_W-1:0] inc,
                             input logic [ACC_W-1:0] ph);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_inc   = inc;
        cfg_phase = ph;
        tick();
        cfg_valid = 1'b0;
    endtask

    // Ticks until running is seen; n is the number of ticks taken (capped).
    task automatic wait_running(output int n);
        n = 0;
        while (!running && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst        = 1'b0;
        pll_locked = 1'b0;
        cfg_valid  = 1'b0;
        cfg_ch     = '0;
        cfg_inc    = '0;
        cfg_phase  = '0;
        realign    = 1'b0;
        #1 rst = 1'b1;
        #1;
        checks++;
        if (ce !== 4'b0000 || running !== 1'b0 || cfg_ready !== 1'b0 || lock_lost_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: ce=%b running=%b cfg_ready=%b lost=%0d expected 0000/0/0/0",
                     ce, running, cfg_ready, lock_lost_cnt);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (cfg_ready !== 1'b1 || running !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_reset: cfg_ready=%b running=%b expected 1/0", cfg_ready, running);
        end
    endtask

    task automatic test_lock_settle();
        // Program channels while unlocked; they take effect at RUN entry.
        cfg_write(2'd0, 32'h4000_0000, 32'h0000_0000);
        cfg_write(2'd1, 32'h8000_0000, 32'h8000_0000);
        cfg_write(2'd2, 32'h5555_5556, 32'h0000_0000);
        cfg_write(2'd3, 32'h0000_0000, 32'h0000_0000);
        pll_locked = 1'b1;
        for (int i = 1; i < LOCK_LAT; i++) begin
            tick();
            checks++;
            if (running !== 1'b0 || ce !== 4'b0000) begin
                errors++;
                $display("FAIL settle_quiet[%0d]: running=%b ce=%b expected 0/0000", i, running, ce);
            end
        end
        tick();
        checks++;
        if (running !== 1'b1 || ce !== 4'b0000) begin
            errors++;
            $display("FAIL run_entry: running=%b ce=%b expected 1/0000", running, ce);
        end
    endtask

    task automatic test_nco_pattern();
        logic [3:0] exp_ce;
        for (int n = 1; n <= 12; n++) begin
            tick();
            exp_ce = {1'b0, (n % 3) == 0, (n % 2) == 1, (n % 4) == 0};
            checks++;
            if (ce !== exp_ce) begin
                errors++;
                $display("FAIL nco_pattern[%0d]: ce=%b expected %b", n, ce, exp_ce);
            end
        end
    endtask

    task automatic test_fractional();
        int c0 = 0;
        int c1 = 0;
        int c2 = 0;
        int c3 = 0;
        for (int n = 0; n < 3000; n++) begin
            tick();
            c0 += int'(ce[0]);
            c1 += int'(ce[1]);
            c2 += int'(ce[2]);
            c3 += int'(ce[3]);
        end
        checks++;
        if (c2 < 999 || c2 > 1001) begin
            errors++;
            $display("FAIL frac_rate_ch2: count=%0d expected 999..1001", c2);
        end
        checks++;
        if (c0 != 750 || c1 != 1500) begin
            errors++;
            $display("FAIL rate_ch0_ch1: counts=%0d/%0d expected 750/1500", c0, c1);
        end
        checks++;
        if (c3 != 0) begin
            errors++;
            $display("FAIL zero_inc_ch3: count=%0d expected 0", c3);
        end
    endtask

    task automatic test_realign_retune();
        logic [3:0] exp_seq [0:4];
        exp_seq[0] = 4'b0011;
        exp_seq[1] = 4'b0000;
        exp_seq[2] = 4'b1110;
        exp_seq[3] = 4'b0000;
        exp_seq[4] = 4'b1011;
        realign   = 1'b1;
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_inc   = 32'h4000_0000;
        cfg_phase = 32'hC000_0000;
        tick();
        realign   = 1'b0;
        cfg_valid = 1'b0;
        checks++;
        if (ce !== 4'b0000) begin
            errors++;
            $display("FAIL realign_edge: ce=%b expected 0000", ce);
        end
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                // Retune channel 3 alone; the others must keep their cadence.
                cfg_valid = 1'b1;
                cfg_ch    = 2'd3;
                cfg_inc   = 32'h8000_0000;
                cfg_phase = 32'h8000_0000;
            end
            tick();
            cfg_valid = 1'b0;
            checks++;
            if (ce !== exp_seq[k]) begin
                errors++;
                $display("FAIL realign_seq[%0d]: ce=%b expected %b", k, ce, exp_seq[k]);
            end
        end
    endtask

    task automatic test_lock_loss();
        int n;
        int bad = 0;
        pll_locked = 1'b0;
        tick();
        tick();
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL lock_loss_sync: running=%b expected 1 (synchroniser delay)", running);
        end
        tick();
        checks++;
        if (running !== 1'b0 || ce !== 4'b0000 || lock_lost_cnt !== 8'd1) begin
            errors++;
            $display("FAIL lock_loss: running=%b ce=%b lost=%0d expected 0/0000/1",
                     running, ce, lock_lost_cnt);
        end
        pll_locked = 1'b1;
        wait_running(n);
        checks++;
        if (n != LOCK_LAT) begin
            errors++;
            $display("FAIL relock_latency: cycles=%0d expected %0d", n, LOCK_LAT);
        end
        for (int i = 2; i <= 300; i++) begin
            pll_locked = 1'b0;
            tick();
            tick();
            tick();
            if (i == 2) begin
                checks++;
                if (lock_lost_cnt !== 8'd2) begin
                    errors++;
                    $display("FAIL lost_cnt_2: lost=%0d expected 2", lock_lost_cnt);
                end
            end
            if (i == 255) begin
                checks++;
                if (lock_lost_cnt !== 8'd255) begin
                    errors++;
                    $display("FAIL lost_cnt_255: lost=%0d expected 255", lock_lost_cnt);
                end
            end
            pll_locked = 1'b1;
            wait_running(n);
            if (n != LOCK_LAT) bad++;
        end
        checks++;
        if (lock_lost_cnt !== 8'd255) begin
            errors++;
            $display("FAIL lost_cnt_saturate: lost=%0d expected 255", lock_lost_cnt);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL relock_loop: bad_relocks=%0d expected 0", bad);
        end
    endtask

    task automatic test_async_reset();
        int n = 0;
        while (ce == 4'b0000 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (ce === 4'b0000) begin
            errors++;
            $display("FAIL pre_reset_activity: ce=%b expected nonzero", ce);
        end
        rst = 1'b1;
        #2;
        checks++;
        if (ce !== 4'b0000 || running !== 1'b0 || cfg_ready !== 1'b0 || lock_lost_cnt !== 8'd0) begin
            errors++;
            $display("FAIL async_reset: ce=%b running=%b cfg_ready=%b lost=%0d expected 0000/0/0/0",
                     ce, running, cfg_ready, lock_lost_cnt);
        end
        tick();
        rst = 1'b0;
        wait_running(n);
        checks++;
        if (n != LOCK_LAT) begin
            errors++;
            $display("FAIL post_reset_lock: cycles=%0d expected %0d", n, LOCK_LAT);
        end
        n = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (ce !== 4'b0000) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL post_reset_inc_cleared: active_cycles=%0d expected 0", n);
        end
    endtask

    initial begin
        test_reset();
        test_lock_settle();
        test_nco_pattern();
        test_fractional();
        test_realign_retune();
        test_lock_loss();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mf_clken_nco
`default_nettype wire
